// File: rtl/tdc_frame_sched.sv
// Snapshot FIFO plus framing FSM: each buffered snapshot of all channels goes out as a
// header word followed by one word per channel enabled in the mask latched at frame start.
module tdc_frame_sched #(
    parameter  int CTR_NUMBER = 8,
    parameter  int FIFO_DEPTH = 4,
    localparam int LW         = $clog2(FIFO_DEPTH + 1),
    localparam int AW         = $clog2(FIFO_DEPTH)
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic [9:0]            snap_data [CTR_NUMBER],
    input  logic                  snap_valid,
    input  logic                  enable,
    input  logic [CTR_NUMBER-1:0] ch_mask,
    output logic [15:0]           out_word,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic [LW-1:0]         fifo_level,
    output logic [7:0]            drop_cnt,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_CH   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [9:0]            mem_q [FIFO_DEPTH][CTR_NUMBER];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]         level_q, level_d;
    logic [7:0]            drop_q, drop_d;
    logic [7:0]            hdr_drop_q, hdr_drop_d;
    logic [5:0]            seq_q, seq_d;
    logic [CTR_NUMBER-1:0] mask_q, mask_d;
    logic [3:0]            ch_idx_q, ch_idx_d;

    logic       full, push, pop, drop;
    logic       first_found, next_found;
    logic [3:0] first_idx, next_idx;
    logic [9:0] head_data;

    assign full = (level_q == LW'(FIFO_DEPTH));
    assign push = snap_valid && enable && (!full || pop);
    assign drop = snap_valid && enable && !push;

    // Lowest set mask bit, and lowest set bit above the current channel.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int i = 0; i < CTR_NUMBER; i++) begin
            if (mask_q[i] && !first_found) begin
                first_found = 1'b1;
                first_idx   = 4'(i);
            end
            if (mask_q[i] && (4'(i) > ch_idx_q) && !next_found) begin
                next_found = 1'b1;
                next_idx   = 4'(i);
            end
        end
    end

    always_comb begin
        head_data = '0;
        for (int i = 0; i < CTR_NUMBER; i++) begin
            if (ch_idx_q == 4'(i)) head_data = mem_q[rd_ptr_q][i];
        end
    end

    // Stream handshake: a word transfers on any cycle with out_valid && out_ready; while
    // out_valid is high without a transfer, out_word/out_last hold and out_valid stays high.
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        hdr_drop_d = hdr_drop_q;
        ch_idx_d   = ch_idx_q;
        seq_d      = seq_q;
        pop        = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_word   = '0;
        case (state_q)
            S_IDLE: begin
                if (level_q != '0) begin
                    state_d    = S_HDR;
                    mask_d     = ch_mask;
                    hdr_drop_d = drop_q;
                end
            end
            S_HDR: begin
                out_valid = 1'b1;
                out_word  = {2'b11, seq_q, hdr_drop_q};
                out_last  = (mask_q == '0);
                if (out_ready) begin
                    if (mask_q == '0) begin
                        pop     = 1'b1;
                        seq_d   = seq_q + 6'd1;
                        state_d = S_IDLE;
                    end else begin
                        ch_idx_d = first_idx;
                        state_d  = S_CH;
                    end
                end
            end
            S_CH: begin
                out_valid = 1'b1;
                out_word  = {2'b01, ch_idx_q, head_data};
                out_last  = !next_found;
                if (out_ready) begin
                    if (!next_found) begin
                        pop     = 1'b1;
                        seq_d   = seq_q + 6'd1;
                        state_d = S_IDLE;
                    end else begin
                        ch_idx_d = next_idx;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        drop_d = (drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            drop_q     <= '0;
            hdr_drop_q <= '0;
            seq_q      <= '0;
            mask_q     <= '0;
            ch_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            drop_q     <= drop_d;
            hdr_drop_q <= hdr_drop_d;
            seq_q      <= seq_d;
            mask_q     <= mask_d;
            ch_idx_q   <= ch_idx_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage needs no reset; validity is tracked entirely by the pointers and level.
    always_ff @(posedge clock) begin
        if (rst && push) begin
            for (int i = 0; i < CTR_NUMBER; i++) mem_q[wr_ptr_q][i] <= snap_data[i];
        end
    end

    assign busy       = (state_q != S_IDLE) || (level_q != '0);
    assign fifo_level = level_q;
    assign drop_cnt   = drop_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_tdc_frame_sched.sv
// Directed bench for tdc_frame_sched: frame vectors from a table plus overflow,
// reset-mid-frame and full-FIFO push/pop sequences.
module tb_tdc_frame_sched;

    localparam int N = 8;
    localparam int D = 4;

    logic        clock = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  snap_data [N];
    logic        snap_valid = 1'b0;
    logic        enable = 1'b1;
    logic [7:0]  ch_mask = 8'h00;
    logic [15:0] out_word;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic        busy;
    logic [2:0]  fifo_level;
    logic [7:0]  drop_cnt;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  mask;
        int          mode;
        logic [15:0] exp_hdr;
    } vec_t;
    vec_t vecs[6];

    tdc_frame_sched #(.CTR_NUMBER(N), .FIFO_DEPTH(D)) dut (
        .clock(clock), .rst(rst), .snap_data(snap_data), .snap_valid(snap_valid),
        .enable(enable), .ch_mask(ch_mask), .out_word(out_word), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .fifo_level(fifo_level),
        .drop_cnt(drop_cnt), .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic set_data(input int base);
        for (int i = 0; i < N; i++) snap_data[i] = 10'(base + i);
    endtask

    task automatic push_snap(input int base);
        set_data(base);
        snap_valid = 1'b1;
        tick();
        snap_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    // Collects one frame and compares it against header + model channel words.
    // mode: 0 ready always, 1 pattern 1,0,0,1,0,1, 2 random.
    task automatic collect_frame(input logic [15:0] exp_hdr, input logic [7:0] mask,
                                 input int base, input int mode, input bit scramble,
                                 output int first_k);
        logic [15:0] exp_q[$];
        logic [15:0] held_w;
        logic [15:0] w;
        logic        held_l;
        bit          stalled;
        bit          done;
        int          got;
        int          n_exp;
        exp_q.push_back(exp_hdr);
        for (int i = 0; i < N; i++)
            if (mask[i]) exp_q.push_back(16'h4000 | (16'(i) << 10) | 16'(base + i));
        n_exp   = exp_q.size();
        stalled = 1'b0;
        done    = 1'b0;
        got     = 0;
        first_k = -1;
        held_w  = '0;
        held_l  = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            if (scramble && k == 1) ch_mask = ~mask;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (k % 6) inside {0, 3, 5};
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (stalled) begin
                check("stall_valid", out_valid, 1);
                check("stall_word", out_word, held_w);
                check("stall_last", out_last, held_l);
            end
            if (out_valid && first_k < 0) first_k = k;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("frame_len_over", got + 1, n_exp);
                end else begin
                    w = exp_q.pop_front();
                    check("word", out_word, w);
                    check("last", out_last, exp_q.size() == 0);
                end
                got++;
                if (out_last) done = 1'b1;
                stalled = 1'b0;
            end else if (out_valid) begin
                stalled = 1'b1;
                held_w  = out_word;
                held_l  = out_last;
            end else begin
                stalled = 1'b0;
            end
            tick();
        end
        out_ready = 1'b0;
        check("frame_done", done, 1);
        check("frame_len", got, n_exp);
    endtask

    initial begin
        int   fk;
        bit   found;
        logic [15:0] ch3_word;

        vecs[0] = '{mask: 8'hFF, mode: 0, exp_hdr: 16'hC000};
        vecs[1] = '{mask: 8'h05, mode: 0, exp_hdr: 16'hC100};
        vecs[2] = '{mask: 8'hFF, mode: 1, exp_hdr: 16'hC200};
        vecs[3] = '{mask: 8'h80, mode: 2, exp_hdr: 16'hC300};
        vecs[4] = '{mask: 8'h00, mode: 1, exp_hdr: 16'hC400};
        vecs[5] = '{mask: 8'h3C, mode: 2, exp_hdr: 16'hC500};

        set_data(0);
        @(negedge clock);
        do_reset();
        check("rst_valid", out_valid, 0);
        check("rst_word", out_word, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_level", fifo_level, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_state", dbg_state, 0);

        // Single-snapshot frames, one per table row, frame_seq counting up.
        for (int v = 0; v < 6; v++) begin
            ch_mask = vecs[v].mask;
            push_snap(100 + 20 * v);
            check("push_level", fifo_level, 1);
            check("push_busy", busy, 1);
            check("push_valid_t", out_valid, 0);
            collect_frame(vecs[v].exp_hdr, vecs[v].mask, 100 + 20 * v, vecs[v].mode, 1'b1, fk);
            check("hdr_latency", fk, 1);
            check("end_busy", busy, 0);
            check("end_level", fifo_level, 0);
            check("end_state", dbg_state, 0);
        end

        // Overflow: six back-to-back strobes with the consumer stalled.
        do_reset();
        ch_mask   = 8'hFF;
        out_ready = 1'b0;
        for (int p = 0; p < 6; p++) push_snap(200 + 16 * p);
        check("ovf_level", fifo_level, 4);
        check("ovf_drop", drop_cnt, 2);
        check("ovf_valid", out_valid, 1);
        check("ovf_hdr", out_word, 16'hC000);
        for (int f = 0; f < 4; f++)
            collect_frame({2'b11, 6'(f), (f == 0) ? 8'd0 : 8'd2}, 8'hFF, 200 + 16 * f, 0, 1'b0, fk);
        check("ovf_drain_level", fifo_level, 0);
        check("ovf_drain_drop", drop_cnt, 2);

        // Reset while channel 3 of a frame is presented.
        ch_mask = 8'hFF;
        push_snap(300);
        out_ready = 1'b1;
        ch3_word  = 16'h4000 | (16'd3 << 10) | 16'd303;
        found     = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            if (out_valid && out_word == ch3_word) begin
                found = 1'b1;
                rst   = 1'b0;
            end
            tick();
        end
        rst       = 1'b1;
        out_ready = 1'b0;
        check("mid_found_ch3", found, 1);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_drop", drop_cnt, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_state", dbg_state, 0);
        push_snap(400);
        collect_frame(16'hC000, 8'hFF, 400, 0, 1'b0, fk);

        // Empty mask on a full FIFO, with a push landing on the pop edge.
        do_reset();
        ch_mask   = 8'h00;
        out_ready = 1'b0;
        for (int p = 0; p < 4; p++) push_snap(500 + p);
        check("full_level", fifo_level, 4);
        check("full_hdr", out_word, 16'hC000);
        check("full_last", out_last, 1);
        set_data(600);
        out_ready  = 1'b1;
        snap_valid = 1'b1;
        tick();
        snap_valid = 1'b0;
        out_ready  = 1'b0;
        check("pp_level", fifo_level, 4);
        check("pp_drop", drop_cnt, 0);
        check("pp_gap_valid", out_valid, 0);
        for (int f = 1; f <= 4; f++)
            collect_frame({2'b11, 6'(f), 8'd0}, 8'h00, 0, 0, 1'b0, fk);
        check("pp_drain_level", fifo_level, 0);

        // Strobes with enable low are neither stored nor counted.
        enable = 1'b0;
        push_snap(700);
        push_snap(710);
        check("dis_level", fifo_level, 0);
        check("dis_drop", drop_cnt, 0);
        check("dis_busy", busy, 0);
        enable = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
